// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for the score/level display: shares one hex
// decoder across N_DIGITS common-anode digits, with a guard gap before each digit.
module seg_scan_ctrl #(
  parameter int unsigned N_DIGITS = 4,
  parameter int unsigned DIV      = 50000,
  parameter int unsigned GUARD    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ld_valid,
  output logic                    ld_ready,
  input  logic [4*N_DIGITS-1:0]   ld_data,
  input  logic [N_DIGITS-1:0]     ld_blank,
  output logic [3:0]              num_out,
  output logic                    seg_blank,
  output logic [N_DIGITS-1:0]     an_n,
  output logic [2:0]              digit_idx,
  output logic                    frame_done
);

  localparam int unsigned CNT_W  = $clog2(DIV);
  localparam int unsigned DATA_W = 4 * N_DIGITS;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD - 1);
  localparam logic [2:0]       IDX_LAST   = 3'(N_DIGITS - 1);

  typedef enum logic {
    PH_GUARD = 1'b0,
    PH_ON    = 1'b1
  } phase_t;

  phase_t                phase_q, phase_nx;
  logic [CNT_W-1:0]      cnt_q, cnt_nx;
  logic [2:0]            idx_q, idx_nx;
  logic [DATA_W-1:0]     act_data_q, act_data_nx;
  logic [N_DIGITS-1:0]   act_blank_q, act_blank_nx;
  logic [DATA_W-1:0]     pend_data_q, pend_data_nx;
  logic [N_DIGITS-1:0]   pend_blank_q, pend_blank_nx;
  logic                  pend_full_q, pend_full_nx;

  logic                  slot_end;
  logic                  frame_end;
  logic                  accept;

  logic [3:0]            num_d;
  logic                  seg_blank_d;
  logic [N_DIGITS-1:0]   an_n_d;
  logic                  ld_ready_d;
  logic                  nib_blank;

  // State register: phase, scan position, both frame buffers and all outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q      <= PH_GUARD;
      cnt_q        <= '0;
      idx_q        <= '0;
      act_data_q   <= '0;
      act_blank_q  <= '1;
      pend_data_q  <= '0;
      pend_blank_q <= '0;
      pend_full_q  <= 1'b0;
      num_out      <= '0;
      seg_blank    <= 1'b1;
      an_n         <= '1;
      digit_idx    <= '0;
      frame_done   <= 1'b0;
      ld_ready     <= 1'b1;
    end else begin
      phase_q      <= phase_nx;
      cnt_q        <= cnt_nx;
      idx_q        <= idx_nx;
      act_data_q   <= act_data_nx;
      act_blank_q  <= act_blank_nx;
      pend_data_q  <= pend_data_nx;
      pend_blank_q <= pend_blank_nx;
      pend_full_q  <= pend_full_nx;
      num_out      <= num_d;
      seg_blank    <= seg_blank_d;
      an_n         <= an_n_d;
      digit_idx    <= idx_nx;
      frame_done   <= frame_end;
      ld_ready     <= ld_ready_d;
    end
  end

  // Next-state: slot timing, phase FSM, and pending/active buffer handoff.
  always_comb begin
    phase_nx      = phase_q;
    cnt_nx        = cnt_q + CNT_W'(1);
    idx_nx        = idx_q;
    act_data_nx   = act_data_q;
    act_blank_nx  = act_blank_q;
    pend_data_nx  = pend_data_q;
    pend_blank_nx = pend_blank_q;
    pend_full_nx  = pend_full_q;

    slot_end  = (cnt_q == CNT_LAST);
    frame_end = slot_end && (idx_q == IDX_LAST);
    accept    = ld_valid && ld_ready;

    if (slot_end) begin
      cnt_nx = '0;
      idx_nx = frame_end ? 3'd0 : idx_q + 3'd1;
    end

    unique case (phase_q)
      PH_GUARD: if (cnt_q == GUARD_LAST) phase_nx = PH_ON;
      PH_ON:    if (slot_end)            phase_nx = PH_GUARD;
      default:  phase_nx = PH_GUARD;
    endcase

    if (frame_end && pend_full_q) begin
      act_data_nx  = pend_data_q;
      act_blank_nx = pend_blank_q;
      pend_full_nx = 1'b0;
    end

    // A load on the boundary edge only fills pending; pending was empty then.
    if (accept) begin
      pend_data_nx  = ld_data;
      pend_blank_nx = ld_blank;
      pend_full_nx  = 1'b1;
    end
  end

  // Output decode from next state so registered outputs match same-cycle state.
  always_comb begin
    num_d       = '0;
    nib_blank   = 1'b1;
    an_n_d      = '1;
    seg_blank_d = 1'b1;
    ld_ready_d  = !pend_full_nx;

    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (idx_nx == 3'(i)) begin
        num_d     = act_data_nx[4*i +: 4];
        nib_blank = act_blank_nx[i];
      end
    end

    if (phase_nx == PH_ON && !nib_blank) begin
      seg_blank_d = 1'b0;
      for (int i = 0; i < int'(N_DIGITS); i++) begin
        if (idx_nx == 3'(i)) an_n_d[i] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl at N_DIGITS=4, DIV=20, GUARD=4.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_valid;
  logic        ld_ready;
  logic [15:0] ld_data;
  logic [3:0]  ld_blank;
  logic [3:0]  num_out;
  logic        seg_blank;
  logic [3:0]  an_n;
  logic [2:0]  digit_idx;
  logic        frame_done;

  int checks = 0;
  int passed = 0;
  int failed = 0;
  int cyc = 0;
  int lit_cnt = 0;
  int unblank_cnt = 0;
  int fd_cnt = 0;

  seg_scan_ctrl #(.N_DIGITS(4), .DIV(20), .GUARD(4)) dut (
    .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_blank(ld_blank), .num_out(num_out),
    .seg_blank(seg_blank), .an_n(an_n), .digit_idx(digit_idx),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to cycle 'target', sampling 1ns after each rising edge.
  task automatic run_to(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
      cyc++;
      if (an_n !== 4'hF) lit_cnt++;
      if (seg_blank !== 1'b1) unblank_cnt++;
      if (frame_done === 1'b1) fd_cnt++;
    end
  endtask

  task automatic clr_counts();
    lit_cnt = 0;
    unblank_cnt = 0;
    fd_cnt = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    ld_valid = 1'b0;
    ld_data = '0;
    ld_blank = '0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_an_n", 16'(an_n), 16'hF);
    chk("rst_seg_blank", 16'(seg_blank), 16'h1);
    chk("rst_ld_ready", 16'(ld_ready), 16'h1);
    chk("rst_frame_done", 16'(frame_done), 16'h0);
    chk("rst_num_out", 16'(num_out), 16'h0);

    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    clr_counts();
    chk("c0_an_n", 16'(an_n), 16'hF);
    chk("c0_frame_done", 16'(frame_done), 16'h0);

    // First load mid-frame 1
    run_to(10);
    ld_valid = 1'b1; ld_data = 16'h4321; ld_blank = 4'b0000;
    run_to(11);
    ld_valid = 1'b0;
    chk("ld_ready_c11", 16'(ld_ready), 16'h0);
    run_to(79);
    chk("ld_ready_c79", 16'(ld_ready), 16'h0);
    chk("frame1_dark", 16'(lit_cnt), 16'h0);
    chk("frame1_blank", 16'(unblank_cnt), 16'h0);
    chk("frame1_no_fd", 16'(fd_cnt), 16'h0);
    run_to(80);
    chk("fd_c80", 16'(frame_done), 16'h1);
    chk("c80_an_n", 16'(an_n), 16'hF);
    chk("c80_num", 16'(num_out), 16'h1);
    run_to(81);
    chk("ld_ready_c81", 16'(ld_ready), 16'h1);
    chk("fd_c81", 16'(frame_done), 16'h0);
    clr_counts();
    run_to(83);
    chk("guard_dark", 16'(lit_cnt), 16'h0);
    run_to(84);
    chk("c84_an_n", 16'(an_n), 16'hE);
    chk("c84_num", 16'(num_out), 16'h1);
    chk("c84_seg_blank", 16'(seg_blank), 16'h0);
    clr_counts();

    // Backpressure: 9876 fills pending, AAAA waits for ld_ready
    run_to(99);
    chk("slot0_lit", 16'(lit_cnt), 16'd15);
    run_to(100);
    ld_valid = 1'b1; ld_data = 16'h9876; ld_blank = 4'b0100;
    run_to(101);
    ld_data = 16'hAAAA; ld_blank = 4'b0000;
    chk("bp_ready_c101", 16'(ld_ready), 16'h0);
    run_to(150);
    chk("c150_an_n", 16'(an_n), 16'h7);
    chk("c150_num", 16'(num_out), 16'h4);
    chk("c150_idx", 16'(digit_idx), 16'h3);
    run_to(159);
    chk("bp_ready_c159", 16'(ld_ready), 16'h0);
    run_to(160);
    chk("bp_ready_c160", 16'(ld_ready), 16'h1);
    run_to(161);
    ld_valid = 1'b0;
    chk("bp_ready_c161", 16'(ld_ready), 16'h0);
    run_to(170);
    chk("c170_an_n", 16'(an_n), 16'hE);
    chk("c170_num", 16'(num_out), 16'h6);
    run_to(190);
    chk("c190_an_n", 16'(an_n), 16'hD);
    chk("c190_num", 16'(num_out), 16'h7);
    run_to(200);
    chk("c200_num", 16'(num_out), 16'h8);
    chk("c200_an_n", 16'(an_n), 16'hF);
    clr_counts();
    run_to(219);
    chk("masked_slot_dark", 16'(lit_cnt), 16'h0);
    chk("masked_slot_blank", 16'(unblank_cnt), 16'h0);
    run_to(230);
    chk("c230_an_n", 16'(an_n), 16'h7);
    chk("c230_num", 16'(num_out), 16'h9);
    run_to(241);
    chk("ld_ready_c241", 16'(ld_ready), 16'h1);
    run_to(250);
    chk("c250_num", 16'(num_out), 16'hA);
    chk("c250_an_n", 16'(an_n), 16'hE);
    run_to(290);
    chk("c290_an_n", 16'(an_n), 16'hB);
    chk("c290_num", 16'(num_out), 16'hA);

    // Collision: 5555 accepted on the frame-boundary edge
    run_to(319);
    chk("ld_ready_c319", 16'(ld_ready), 16'h1);
    ld_valid = 1'b1; ld_data = 16'h5555; ld_blank = 4'b0000;
    run_to(320);
    ld_valid = 1'b0;
    chk("fd_c320", 16'(frame_done), 16'h1);
    chk("ld_ready_c320", 16'(ld_ready), 16'h0);
    chk("c320_num", 16'(num_out), 16'hA);
    run_to(330);
    chk("c330_num", 16'(num_out), 16'hA);
    chk("c330_an_n", 16'(an_n), 16'hE);
    run_to(401);
    chk("ld_ready_c401", 16'(ld_ready), 16'h1);
    run_to(410);
    chk("c410_num", 16'(num_out), 16'h5);
    chk("c410_an_n", 16'(an_n), 16'hE);

    // Mid-slot reset with pending full
    run_to(415);
    ld_valid = 1'b1; ld_data = 16'hBEEF; ld_blank = 4'b0000;
    run_to(416);
    ld_valid = 1'b0;
    run_to(430);
    chk("c430_an_n", 16'(an_n), 16'hD);
    chk("c430_num", 16'(num_out), 16'h5);
    chk("c430_ready", 16'(ld_ready), 16'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_an_n", 16'(an_n), 16'hF);
    chk("async_seg_blank", 16'(seg_blank), 16'h1);
    chk("async_ready", 16'(ld_ready), 16'h1);
    chk("async_num", 16'(num_out), 16'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    clr_counts();
    run_to(25);
    chk("r2_c25_idx", 16'(digit_idx), 16'h1);
    chk("r2_c25_num", 16'(num_out), 16'h0);
    run_to(200);
    chk("r2_dark", 16'(lit_cnt), 16'h0);
    chk("r2_blank", 16'(unblank_cnt), 16'h0);
    chk("r2_fd_count", 16'(fd_cnt), 16'd2);
    chk("r2_ready", 16'(ld_ready), 16'h1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller that shares one `seven_seg` hex decoder across `N_DIGITS` common-anode digits of the Simon's Game score/level display. It holds a double-buffered frame of digit nibbles and blank flags, loaded by the game FSM over a valid/ready handshake. It drives the decoder input `num_out` and the active-low digit enables `an_n`, and inserts an all-off guard interval before every digit to suppress ghosting. Top level forces segments to 7'h7F whenever `seg_blank` is 1.

## Interface
- `N_DIGITS`, default 4: number of digits scanned; legal range 1..8.
- `DIV`, default 50000: clock cycles per digit slot; requires DIV ≥ GUARD+2.
- `GUARD`, default 16: all-off cycles at the start of each slot; requires GUARD ≥ 1.

- `clk` in 1: system clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ld_valid` in 1: game FSM offers a new frame.
- `ld_ready` out 1: pending buffer empty; a transfer occurs when `ld_valid && ld_ready` at a clock edge.
- `ld_data` in 4*N_DIGITS: nibble i (bits 4i+3:4i) is the value for digit i.
- `ld_blank` in N_DIGITS: bit i = 1 keeps digit i dark.
- `num_out` out 4: drives `seven_seg.num_in`; equals the active nibble of the current digit.
- `seg_blank` out 1: 1 = segments must be forced off.
- `an_n` out N_DIGITS: active-low digit enables; at most one bit is 0 at any time.
- `digit_idx` out 3: index of the current slot.
- `frame_done` out 1: one-cycle pulse at the start of each frame.

## Operation
- State: slot counter `cnt` (0..DIV-1), digit index `idx` (0..N_DIGITS-1), phase FSM {GUARD, ON}, active buffer (data+blank), pending buffer, and `pending_full`.
- Phase FSM: GUARD while cnt < GUARD; ON while GUARD ≤ cnt ≤ DIV-1. At cnt == DIV-1, next is cnt=0 and phase GUARD.
- Slot advance at cnt == DIV-1: idx increments. It wraps from N_DIGITS-1 to 0; this edge is the frame boundary.
- GUARD outputs: an_n all 1s, seg_blank=1.
- ON outputs: if active_blank[idx]=0, an_n has only bit idx at 0 and seg_blank=0. Otherwise an_n all 1s and seg_blank=1.
- num_out = active_data[idx] in both phases. digit_idx = idx.
- Load: on a handshake, ld_data/ld_blank go into the pending buffer and pending_full is set. ld_ready = !pending_full.
- Frame boundary: if pending_full, copy pending to active and clear pending_full. Otherwise active is unchanged.
- Load accepted on the frame-boundary edge: the new data goes to pending only and is promoted at the next boundary. There is no bypass.
- Outputs num_out, an_n, seg_blank, digit_idx, frame_done, ld_ready are registers with no combinational path from the inputs. Each reflects the cnt/idx/active state of the same cycle.
- N_DIGITS=1: idx stays 0; every slot end is a frame boundary.

## Timing
- Reset values: cnt=0, idx=0, phase GUARD, active_data=0, active_blank all 1s (display dark), pending_full=0.
- Output reset values: an_n all 1s, seg_blank=1, num_out=0, digit_idx=0, frame_done=0, ld_ready=1.
- Reset mid-operation takes effect immediately (asynchronous). Pending contents are discarded and the display goes dark.
- Slot k occupies cycles k*DIV .. k*DIV+DIV-1 after reset release. The digit is lit for the last DIV-GUARD cycles of its slot.
- frame_done is 1 in the first cycle of each frame (cnt=0, idx=0). It is not asserted in the first cycle after reset release.
- ld_ready falls in the cycle after an accepting edge. It rises in the cycle after the frame boundary that empties pending.
- Load-to-display latency is at most 2*N_DIGITS*DIV cycles. This worst case occurs when the load is accepted exactly on a boundary edge.
- Frame period is N_DIGITS*DIV cycles.

## Test plan
All tests use N_DIGITS=4, DIV=20, GUARD=4.
- Reset: hold rst_n=0 for 5 cycles -> an_n=4'b1111, seg_blank=1, ld_ready=1, frame_done=0. After release the first 80 cycles stay dark, and frame_done pulses at cycle 80.
- Load 16'h4321 with blank 4'b0000 at cycle 10 -> ld_ready=0 from cycle 11 and ld_ready=1 at cycle 81. In frame 2, slot 0 shows an_n=4'b1111 for cnt 0..3, then an_n=4'b1110, num_out=1, seg_blank=0 for cnt 4..19. Slot 3 shows an_n=4'b0111, num_out=4.
- Backpressure: offer 16'hAAAA while pending is full, holding ld_valid high -> no transfer until ld_ready=1. The next frame then shows A on all digits.
- Blank mask: load 16'h9876 with blank 4'b0100 -> slot 2 keeps an_n=4'b1111 and seg_blank=1 for the whole slot; the other digits light normally.
- Boundary collision: accept 16'h5555 on the frame-boundary edge -> the current frame still shows the old data, and 5s appear one frame later.
- Mid-slot reset with pending full -> outputs go dark immediately and ld_ready=1. After release the old pending data is never displayed.
